lif_scheduler: RTL

- Time-multiplexes one shared LIF update datapath across NUM_NEURONS virtual neurons.
- Holds per-neuron membrane state and weight in register files.
- On each timestep tick, sweeps neurons in index order, one update per cycle.
- Emits spike events over a valid/ready stream and publishes a per-timestep spike vector; sits between the input/timestep source and downstream spike consumers.

---
 rtl/lif_pkg.sv | 8 +
 rtl/lif_update_core.sv | 23 ++
 rtl/lif_scheduler.sv | 101 ++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// Shared widths, FSM encoding and default neuron constants for the LIF scheduler.
package lif_pkg;
  localparam int DATA_W        = 8;
  localparam int DEF_THRESHOLD = 200;
  localparam int DEF_BIAS      = 0;

  typedef enum logic [1:0] {IDLE, UPDATE, EMIT, DONE} lif_state_t;
endpackage

// File: rtl/lif_update_core.sv
// Combinational LIF update: leak by halving, integrate weighted current plus bias, threshold.
module lif_update_core import lif_pkg::*; #(
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int BIAS           = DEF_BIAS,
  parameter int RESET_ON_SPIKE = 1
) (
  input  logic [DATA_W-1:0] current,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] state,
  output logic [DATA_W-1:0] next,
  output logic              spike
);
  logic [DATA_W-1:0] prod;
  logic [DATA_W-1:0] sum;

  // next is the membrane value written back, so reset-on-spike is folded in here
  always_comb begin
    prod  = current * weight;
    sum   = prod + DATA_W'(BIAS) + (state >> 1);
    spike = (sum >= DATA_W'(THRESHOLD));
    next  = (spike && (RESET_ON_SPIKE != 0)) ? '0 : sum;
  end
endmodule

// File: rtl/lif_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons through one shared update core per timestep tick.
module lif_scheduler import lif_pkg::*; #(
  parameter int NUM_NEURONS    = 8,
  parameter int THRESHOLD      = DEF_THRESHOLD,
  parameter int BIAS           = DEF_BIAS,
  parameter int RESET_ON_SPIKE = 1,
  localparam int IW            = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic [DATA_W-1:0]      current_in,
  input  logic                   cfg_we,
  input  logic [IW-1:0]          cfg_addr,
  input  logic [DATA_W-1:0]      cfg_data,
  output logic                   evt_valid,
  output logic [IW-1:0]          evt_id,
  input  logic                   evt_ready,
  output logic [NUM_NEURONS-1:0] spike_vec,
  output logic                   done,
  output logic                   busy,
  output logic                   tick_drop
);
  lif_state_t                             fsm;
  logic [NUM_NEURONS-1:0][DATA_W-1:0]     state_rf;
  logic [NUM_NEURONS-1:0][DATA_W-1:0]     weight_rf;
  logic [DATA_W-1:0]                      cur_latch;
  logic [IW-1:0]                          idx;
  logic [NUM_NEURONS-1:0]                 work;
  logic [DATA_W-1:0]                      upd_next;
  logic                                   upd_spike;
  logic                                   last;

  assign last = (idx == IW'(NUM_NEURONS - 1));

  lif_update_core #(
    .THRESHOLD      (THRESHOLD),
    .BIAS           (BIAS),
    .RESET_ON_SPIKE (RESET_ON_SPIKE)
  ) u_core (
    .current (cur_latch),
    .weight  (weight_rf[idx]),
    .state   (state_rf[idx]),
    .next    (upd_next),
    .spike   (upd_spike)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm       <= IDLE;
      state_rf  <= '0;
      weight_rf <= '0;
      cur_latch <= '0;
      idx       <= '0;
      work      <= '0;
      spike_vec <= '0;
      evt_id    <= '0;
      tick_drop <= 1'b0;
    end else begin
      tick_drop <= tick && (fsm != IDLE);
      // the core reads weight_rf before this write lands, so a same-index write takes effect next timestep
      if (cfg_we) weight_rf[cfg_addr] <= cfg_data;
      case (fsm)
        IDLE: if (tick) begin
          cur_latch <= current_in;
          idx       <= '0;
          work      <= '0;
          fsm       <= UPDATE;
        end
        UPDATE: begin
          state_rf[idx] <= upd_next;
          if (upd_spike) begin
            work[idx] <= 1'b1;
            evt_id    <= idx;
            fsm       <= EMIT;
          end else if (last) begin
            fsm <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        EMIT: if (evt_ready) begin
          if (last) fsm <= DONE;
          else begin
            idx <= idx + 1'b1;
            fsm <= UPDATE;
          end
        end
        DONE: begin
          spike_vec <= work;
          fsm       <= IDLE;
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign evt_valid = (fsm == EMIT);
  assign done      = (fsm == DONE);
  assign busy      = (fsm != IDLE);
endmodule
